// File: rtl/grf_hazard_scoreboard_pkg.sv
// grf_hazard_scoreboard_pkg: shared widths, stage/forward encodings and entry layout
package grf_hazard_scoreboard_pkg;
    localparam int NREG_DEF = 32;
    localparam int TW_DEF   = 2;
    localparam int AW       = 5;
    localparam int AGE_W    = 2;
    localparam int TNEW_W   = 2;

    localparam logic [AGE_W-1:0] AGE_E    = 2'd1;
    localparam logic [AGE_W-1:0] AGE_LAST = 2'd3;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_EM  = 2'd1,
        FWD_MW  = 2'd2,
        FWD_W   = 2'd3
    } fwd_e;

    typedef struct packed {
        logic              valid;
        logic [AGE_W-1:0]  age;
        logic [TNEW_W-1:0] tnew;
    } entry_t;
endpackage

// File: rtl/grf_hazard_scoreboard_entry.sv
// grf_hazard_scoreboard_entry: one register's in-flight write tracker (insert, age, retire)
module grf_hazard_scoreboard_entry
    import grf_hazard_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              i_ins,
    input  logic [TNEW_W-1:0] i_tnew,
    output entry_t            o_entry
);
    entry_t r_entry;

    assign o_entry = r_entry;

    // Insert wins over aging so the youngest writer owns the entry; retire after W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_entry <= '0;
        end else if (!hold) begin
            if (i_ins) begin
                r_entry <= '{valid: 1'b1, age: AGE_E, tnew: i_tnew};
            end else if (r_entry.valid) begin
                r_entry.valid <= (r_entry.age != AGE_LAST);
                r_entry.age   <= r_entry.age + 1'b1;
                r_entry.tnew  <= (r_entry.tnew == '0) ? '0 : r_entry.tnew - 1'b1;
            end
        end
    end
endmodule

// File: rtl/grf_hazard_scoreboard.sv
// grf_hazard_scoreboard: per-register GRF write tracking, Tnew/Tuse stall and forward selects
module grf_hazard_scoreboard
    import grf_hazard_scoreboard_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int TW   = TW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_addr,
    input  logic [TW-1:0]   issue_tnew,
    input  logic            rs_used,
    input  logic            rt_used,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    input  logic [TW-1:0]   rs_tuse,
    input  logic [TW-1:0]   rt_tuse,
    output logic            stall,
    output logic [1:0]      fwd_rs,
    output logic [1:0]      fwd_rt,
    output logic [NREG-1:0] busy_mask
);
    entry_t            w_ent [NREG];
    entry_t            w_rs;
    entry_t            w_rt;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_fire;
    logic [TNEW_W-1:0] w_ins_tnew;

    assign w_ent[0] = '0;

    if (TW > TNEW_W) begin : g_clip
        assign w_ins_tnew = (|issue_tnew[TW-1:TNEW_W]) ? '1 : issue_tnew[TNEW_W-1:0];
    end else begin : g_noclip
        assign w_ins_tnew = TNEW_W'(issue_tnew);
    end

    assign w_fire = issue_valid & issue_we & ~stall & ~hold & (issue_addr != '0);

    for (genvar i = 1; i < NREG; i++) begin : g_ent
        grf_hazard_scoreboard_entry u_ent (
            .clk     (clk),
            .reset   (reset),
            .hold    (hold),
            .i_ins   (w_fire && (issue_addr == AW'(i))),
            .i_tnew  (w_ins_tnew),
            .o_entry (w_ent[i])
        );
    end

    // Two identical read ports: stall when the result is not ready by Tuse, forward once Tnew hits 0
    always_comb begin
        w_rs     = w_ent[rs_addr];
        w_rt     = w_ent[rt_addr];
        w_rs_hit = rs_used && (rs_addr != '0) && w_rs.valid;
        w_rt_hit = rt_used && (rt_addr != '0) && w_rt.valid;
        stall    = issue_valid && ((w_rs_hit && (TW'(w_rs.tnew) > rs_tuse)) ||
                                   (w_rt_hit && (TW'(w_rt.tnew) > rt_tuse)));
        fwd_rs   = (w_rs_hit && (w_rs.tnew == '0)) ? w_rs.age : FWD_GRF;
        fwd_rt   = (w_rt_hit && (w_rt.tnew == '0)) ? w_rt.age : FWD_GRF;
    end

    // Debug view of which entries currently hold an in-flight write
    always_comb begin
        for (int k = 0; k < NREG; k++) busy_mask[k] = w_ent[k].valid;
    end
endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// tb_grf_hazard_scoreboard: directed scenarios plus randomized traffic against a cycle-count model
module tb_grf_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [1:0]  issue_tnew = '0;
    logic        rs_used = 1'b0;
    logic        rt_used = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [1:0]  rs_tuse = '0;
    logic [1:0]  rt_tuse = '0;
    logic        stall;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [31:0] busy_mask;

    int vecs = 0;
    int errs = 0;
    int since [32];
    int t0 [32];

    grf_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .hold(hold),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_addr(issue_addr), .issue_tnew(issue_tnew),
        .rs_used(rs_used), .rt_used(rt_used), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    // Model: a write is visible for 3 unheld cycles after issue; its Tnew counts down per cycle
    function automatic bit m_valid(int r);
        return r != 0 && since[r] >= 0 && since[r] <= 2;
    endfunction

    function automatic int m_tnew(int r);
        return (t0[r] - since[r] > 0) ? t0[r] - since[r] : 0;
    endfunction

    function automatic bit m_src_stall(bit u, int a, int tuse);
        return u && m_valid(a) && m_tnew(a) > tuse;
    endfunction

    function automatic bit m_stall();
        return issue_valid && (m_src_stall(rs_used, int'(rs_addr), int'(rs_tuse)) ||
                               m_src_stall(rt_used, int'(rt_addr), int'(rt_tuse)));
    endfunction

    function automatic logic [1:0] m_fwd(bit u, int a);
        return (u && m_valid(a) && m_tnew(a) == 0) ? 2'(since[a] + 1) : 2'd0;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = m_valid(r);
        return m;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            since[r] = -1;
            t0[r] = 0;
        end
    endtask

    task automatic tick();
        bit fire;
        fire = issue_valid && issue_we && !m_stall() && !hold && issue_addr != 0;
        @(posedge clk);
        if (reset && !hold) begin
            for (int r = 0; r < 32; r++)
                if (since[r] >= 0) since[r] = (since[r] >= 2) ? -1 : since[r] + 1;
            if (fire) begin
                since[issue_addr] = 0;
                t0[issue_addr] = int'(issue_tnew);
            end
        end
        #1;
    endtask

    task automatic set_issue(input logic v, input logic we, input logic [4:0] a, input logic [1:0] t);
        issue_valid = v; issue_we = we; issue_addr = a; issue_tnew = t;
    endtask

    task automatic set_rs(input logic u, input logic [4:0] a, input logic [1:0] t);
        rs_used = u; rs_addr = a; rs_tuse = t;
    endtask

    task automatic set_rt(input logic u, input logic [4:0] a, input logic [1:0] t);
        rt_used = u; rt_addr = a; rt_tuse = t;
    endtask

    task automatic do_reset();
        set_issue(0, 0, 0, 0); set_rs(0, 0, 0); set_rt(0, 0, 0);
        hold = 1'b0;
        reset = 1'b0;
        m_clear();
        #12;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_clear();
        set_issue(1, 1, 8, 2); set_rs(1, 8, 0); set_rt(1, 8, 0);
        repeat (2) @(posedge clk);
        #2;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset stall: got %0b want 0", stall); end
        vecs++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errs++; $display("FAIL reset fwd: got %0d/%0d want 0/0", fwd_rs, fwd_rt); end
        vecs++; if (busy_mask !== 32'd0) begin errs++; $display("FAIL reset busy: got %h want 0", busy_mask); end
        do_reset();
    endtask

    task automatic test_load_use();
        bit         es [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] ef [3] = '{2'd0, 2'd0, 2'd3};
        do_reset();
        set_issue(1, 1, 8, 2);
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL load_use first issue stall: got %0b want 0", stall); end
        tick();
        set_issue(1, 0, 0, 0); set_rs(1, 8, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if (stall !== es[c]) begin errs++; $display("FAIL load_use stall c%0d: got %0b want %0b", c, stall, es[c]); end
            vecs++; if (fwd_rs !== ef[c]) begin errs++; $display("FAIL load_use fwd_rs c%0d: got %0d want %0d", c, fwd_rs, ef[c]); end
            tick();
        end
    endtask

    task automatic test_forward();
        do_reset();
        set_issue(1, 1, 9, 1);
        tick();
        set_issue(1, 1, 10, 1); set_rs(1, 9, 1);
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fwd alu-alu stall: got %0b want 0", stall); end
        vecs++; if (fwd_rs !== 2'd0) begin errs++; $display("FAIL fwd alu-alu fwd_rs: got %0d want 0", fwd_rs); end
        tick();
        set_issue(1, 0, 0, 0); set_rs(1, 9, 1); set_rt(1, 10, 0);
        #1;
        vecs++; if (fwd_rs !== 2'd2) begin errs++; $display("FAIL fwd next fwd_rs: got %0d want 2", fwd_rs); end
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL fwd rt not ready stall: got %0b want 1", stall); end
        vecs++; if (fwd_rt !== 2'd0) begin errs++; $display("FAIL fwd stalled rt fwd_rt: got %0d want 0", fwd_rt); end
        set_rt(0, 0, 0);
    endtask

    task automatic test_waw();
        logic [1:0] ef [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        set_issue(1, 1, 8, 2);
        tick();
        set_issue(1, 1, 8, 1);
        tick();
        set_issue(1, 0, 0, 0); set_rs(1, 8, 1);
        for (int c = 0; c < 4; c++) begin
            #1;
            vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL waw stall c%0d: got %0b want 0", c, stall); end
            vecs++; if (fwd_rs !== ef[c]) begin errs++; $display("FAIL waw fwd_rs c%0d: got %0d want %0d", c, fwd_rs, ef[c]); end
            vecs++; if (busy_mask[8] !== eb[c]) begin errs++; $display("FAIL waw busy8 c%0d: got %0b want %0b", c, busy_mask[8], eb[c]); end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_issue(1, 1, 0, 3);
        tick();
        set_issue(1, 0, 0, 0); set_rs(1, 0, 0); set_rt(1, 0, 0);
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL zero stall: got %0b want 0", stall); end
        vecs++; if (fwd_rs !== 2'd0) begin errs++; $display("FAIL zero fwd_rs: got %0d want 0", fwd_rs); end
        vecs++; if (busy_mask !== 32'd0) begin errs++; $display("FAIL zero busy: got %h want 0", busy_mask); end
        set_rt(0, 0, 0);
    endtask

    task automatic test_hold();
        bit         es [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] ef [3] = '{2'd0, 2'd0, 2'd3};
        do_reset();
        set_issue(1, 1, 8, 2);
        tick();
        set_issue(1, 1, 5, 1); set_rs(1, 8, 0);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL hold stall c%0d: got %0b want 1", c, stall); end
            vecs++; if (busy_mask !== 32'h100) begin errs++; $display("FAIL hold busy c%0d: got %h want 00000100", c, busy_mask); end
            tick();
        end
        hold = 1'b0;
        set_issue(1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if (stall !== es[c]) begin errs++; $display("FAIL hold resume stall c%0d: got %0b want %0b", c, stall, es[c]); end
            vecs++; if (fwd_rs !== ef[c]) begin errs++; $display("FAIL hold resume fwd_rs c%0d: got %0d want %0d", c, fwd_rs, ef[c]); end
            tick();
        end
        set_rs(0, 0, 0);
        hold = 1'b1;
        set_issue(1, 1, 6, 1);
        tick();
        hold = 1'b0;
        set_issue(0, 0, 0, 0);
        #1;
        vecs++; if (busy_mask[6] !== 1'b0) begin errs++; $display("FAIL hold blocks insert: got %0b want 0", busy_mask[6]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int r = 3; r <= 5; r++) begin
            set_issue(1, 1, 5'(r), 2);
            tick();
        end
        set_issue(1, 0, 0, 0); set_rs(1, 5, 0);
        #1;
        vecs++; if (busy_mask !== 32'h38) begin errs++; $display("FAIL areset inflight busy: got %h want 00000038", busy_mask); end
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL areset inflight stall: got %0b want 1", stall); end
        #1;
        reset = 1'b0;
        #1;
        vecs++; if (busy_mask !== 32'd0) begin errs++; $display("FAIL areset busy: got %h want 0", busy_mask); end
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL areset stall: got %0b want 0", stall); end
        m_clear();
        #10;
        reset = 1'b1;
        set_issue(1, 1, 7, 1); set_rs(1, 5, 0);
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL post-reset stall: got %0b want 0", stall); end
        tick();
        set_issue(0, 0, 0, 0); set_rs(0, 0, 0);
        #1;
        vecs++; if (busy_mask !== 32'h80) begin errs++; $display("FAIL post-reset insert busy: got %h want 00000080", busy_mask); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(0, 7) == 0);
            set_issue($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            set_rs($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            set_rt($urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            #1;
            vecs++; if (stall !== m_stall()) begin errs++; $display("FAIL rand stall c%0d: got %0b want %0b", c, stall, m_stall()); end
            vecs++; if (fwd_rs !== m_fwd(rs_used, int'(rs_addr))) begin errs++; $display("FAIL rand fwd_rs c%0d: got %0d want %0d", c, fwd_rs, m_fwd(rs_used, int'(rs_addr))); end
            vecs++; if (fwd_rt !== m_fwd(rt_used, int'(rt_addr))) begin errs++; $display("FAIL rand fwd_rt c%0d: got %0d want %0d", c, fwd_rt, m_fwd(rt_used, int'(rt_addr))); end
            vecs++; if (busy_mask !== m_mask()) begin errs++; $display("FAIL rand busy c%0d: got %h want %h", c, busy_mask, m_mask()); end
            tick();
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_waw();
        test_zero_reg();
        test_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
